// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Playback position generator for the 7-segment animation engine. Holds the
//   current animation index, which drives an external frame-limit lookup.
//   Steps a frame index from 0 to limit-1 at a prescaled tick rate. At the end
//   of each sequence it can advance to the next animation. Pause, single-step
//   and reload requests come from the control logic.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ena          global enable; low freezes all state and forces pulses to 0
//   animation_in animation index captured on load
//   load         single-cycle strobe: take animation_in, restart at frame 0
//   pause        level; high holds playback
//   step         single-step request while paused (rising edge used)
//   auto_next    level; high increments animation at sequence end
//   limit        frames in current animation (0 encodes 32), combinational
//                from animation
//   animation    current animation index
//   frame        current frame index
//   frame_tick   one-cycle pulse on every frame advance
//   seq_done     one-cycle pulse when frame wraps to 0 at sequence end
//
// Strobe semantics: load and step are sampled on the rising clock edge while
// ena=1. A load is consumed in the cycle it is seen. A step counts only on a
// 0->1 transition, measured against the previous cycle's step level. There is
// no back-pressure.

module frame_sequencer #(
  parameter int TICK_DIV = 5000000,
  parameter int DIV_W    = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [5:0] animation_in,
  input  logic       load,
  input  logic       pause,
  input  logic       step,
  input  logic       auto_next,
  input  logic [4:0] limit,
  output logic [5:0] animation,
  output logic [4:0] frame,
  output logic       frame_tick,
  output logic       seq_done
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_PAUSED = 2'd1,
    S_RELOAD = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic [4:0]       frame_nxt;
  logic [5:0]       anim_nxt;
  logic             tick_nxt;
  logic             done_nxt;
  logic             step_q;
  logic             step_edge;
  logic             adv;
  logic [4:0]       last;

  // Mod-32 subtraction: limit=0 (32 frames) gives last=31.
  assign last      = limit - 5'd1;
  assign step_edge = step & ~step_q;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    frame_nxt = frame;
    anim_nxt  = animation;
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    adv       = 1'b0;

    if (ena) begin
      if (load) begin
        // Load wins over any coincident tick or step; that advance is dropped.
        anim_nxt  = animation_in;
        frame_nxt = 5'd0;
        presc_nxt = '0;
        state_nxt = S_RELOAD;
      end else begin
        case (state)
          S_RUN: begin
            // A wrap at TICK_DIV-1 gives a period of exactly TICK_DIV cycles.
            if (presc == PRESC_MAX) begin
              presc_nxt = '0;
              adv       = 1'b1;
            end else begin
              presc_nxt = presc + 1'b1;
            end
            if (pause) state_nxt = S_PAUSED;
          end
          S_PAUSED: begin
            // The prescaler is held here, so resuming continues the interval.
            adv = step_edge;
            if (!pause) state_nxt = S_RUN;
          end
          S_RELOAD: begin
            presc_nxt = '0;
            state_nxt = pause ? S_PAUSED : S_RUN;
          end
          default: state_nxt = S_RUN;
        endcase
      end

      if (adv) begin
        tick_nxt = 1'b1;
        // Using >= lets a limit that shrank under a running frame recover.
        if (frame >= last) begin
          frame_nxt = 5'd0;
          done_nxt  = 1'b1;
          if (auto_next) anim_nxt = animation + 6'd1;
        end else begin
          frame_nxt = frame + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RUN;
      presc      <= '0;
      frame      <= 5'd0;
      animation  <= 6'd0;
      frame_tick <= 1'b0;
      seq_done   <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      frame      <= frame_nxt;
      animation  <= anim_nxt;
      frame_tick <= tick_nxt;
      seq_done   <= done_nxt;
      // Sampled even while ena=0, so no stale edge appears when ena rises.
      step_q     <= step;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer
//   Directed bench for frame_sequencer with TICK_DIV=4. A small lookup model
//   supplies limit from the animation output. The lookup can be overridden to
//   force specific limits.

module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [5:0] animation_in;
  logic       load;
  logic       pause;
  logic       step;
  logic       auto_next;
  logic [4:0] limit;
  logic [5:0] animation;
  logic [4:0] frame;
  logic       frame_tick;
  logic       seq_done;

  logic       lim_ovr_en;
  logic [4:0] lim_ovr;

  int n_tests = 0;
  int n_fail  = 0;

  frame_sequencer #(.TICK_DIV(4), .DIV_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .ena          (ena),
    .animation_in (animation_in),
    .load         (load),
    .pause        (pause),
    .step         (step),
    .auto_next    (auto_next),
    .limit        (limit),
    .animation    (animation),
    .frame        (frame),
    .frame_tick   (frame_tick),
    .seq_done     (seq_done)
  );

  // clock
  always #5 clk = ~clk;

  // frame-limit lookup model
  function automatic logic [4:0] lut(input logic [5:0] a);
    case (a)
      6'd0:    return 5'd10;
      6'd1:    return 5'd0;
      6'd16:   return 5'd12;
      6'd63:   return 5'd2;
      default: return 5'd8;
    endcase
  endfunction

  always_comb limit = lim_ovr_en ? lim_ovr : lut(animation);

  // step past the next rising edge; sample and drive at +1
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // wait for a frame_tick, bounded; n is cycles consumed
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!frame_tick && n < max);
  endtask

  typedef struct {
    logic       ena;
    logic       step;
    logic [4:0] exp_frame;
    logic       exp_tick;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n;
    // step / ena vectors applied while paused at frame 3
    vecs[0]  = '{1'b1, 1'b1, 5'd4, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 5'd4, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 5'd5, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 5'd5, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'd5, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5'd6, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 5'd6, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd6, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 5'd6, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'd6, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 5'd7, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 5'd7, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 5'd7, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 5'd7, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 5'd7, 1'b0};

    reset = 1'b1; ena = 1'b1; animation_in = 6'd0; load = 1'b0;
    pause = 1'b0; step = 1'b0; auto_next = 1'b0;
    lim_ovr_en = 1'b0; lim_ovr = 5'd0;

    // reset state
    repeat (2) cyc();
    check("rst_frame", frame, 0);
    check("rst_anim", animation, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_done", seq_done, 0);

    // 1: limit 10, a frame every 4 cycles, wrap with seq_done
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      repeat (3) begin
        cyc();
        check("t1_no_tick", frame_tick, 0);
      end
      cyc();
      check("t1_tick", frame_tick, 1);
      check("t1_frame", frame, k % 10);
      check("t1_done", seq_done, (k == 10) ? 1 : 0);
      check("t1_anim", animation, 0);
    end
    cyc();
    check("t1_done_single", seq_done, 0);

    // 2: auto_next wraps animation 63 -> 0 with limit 2
    auto_next = 1'b1; animation_in = 6'd63; load = 1'b1;
    cyc();
    load = 1'b0;
    check("t2_load_anim", animation, 63);
    wait_tick(10, n);
    check("t2_lat1", n, 5);
    check("t2_frame1", frame, 1);
    check("t2_done1", seq_done, 0);
    wait_tick(10, n);
    check("t2_lat2", n, 4);
    check("t2_frame_wrap", frame, 0);
    check("t2_done2", seq_done, 1);
    check("t2_anim_wrap", animation, 0);
    auto_next = 1'b0;

    // 3: limit 0 means 32 frames
    lim_ovr_en = 1'b1; lim_ovr = 5'd0;
    for (int k = 1; k <= 32; k++) begin
      wait_tick(8, n);
      check("t3_lat", n, 4);
      check("t3_frame", frame, k % 32);
      check("t3_done", seq_done, (k == 32) ? 1 : 0);
    end
    check("t3_anim", animation, 0);
    lim_ovr_en = 1'b0;

    // 4: pause at frame 3, then table-driven step / ena vectors
    repeat (3) wait_tick(8, n);
    check("t4_frame3", frame, 3);
    pause = 1'b1;
    n = 0;
    repeat (20) begin
      cyc();
      if (frame_tick) n++;
    end
    check("t4_hold_frame", frame, 3);
    check("t4_hold_ticks", n, 0);
    for (int i = 0; i < 15; i++) begin
      ena  = vecs[i].ena;
      step = vecs[i].step;
      cyc();
      check($sformatf("t4_vec%0d_frame", i), frame, vecs[i].exp_frame);
      check($sformatf("t4_vec%0d_tick", i), frame_tick, vecs[i].exp_tick);
    end
    ena = 1'b1; step = 1'b0;
    // resume: prescaler was held at 1, so 4 cycles to the next advance
    pause = 1'b0;
    wait_tick(10, n);
    check("t4_resume_lat", n, 4);
    check("t4_resume_frame", frame, 8);

    // 5: load coincident with a tick
    for (int k = 0; k < 20 && frame != 5; k++) wait_tick(8, n);
    check("t5_frame5", frame, 5);
    repeat (3) cyc();
    animation_in = 6'd16; load = 1'b1;
    cyc();
    load = 1'b0;
    check("t5_anim", animation, 16);
    check("t5_frame", frame, 0);
    check("t5_no_tick", frame_tick, 0);
    check("t5_no_done", seq_done, 0);
    wait_tick(10, n);
    check("t5_lat", n, 5);
    check("t5_frame1", frame, 1);

    // 6: limit shrinks 12 -> 6 while frame=9
    for (int k = 0; k < 20 && frame != 9; k++) wait_tick(8, n);
    check("t6_frame9", frame, 9);
    lim_ovr_en = 1'b1; lim_ovr = 5'd6;
    wait_tick(8, n);
    check("t6_frame_recover", frame, 0);
    check("t6_done", seq_done, 1);
    check("t6_anim_kept", animation, 16);
    lim_ovr_en = 1'b0;
    wait_tick(8, n);
    check("t6_frame1", frame, 1);
    cyc();
    reset = 1'b1;
    #2;
    check("t6_async_frame", frame, 0);
    check("t6_async_anim", animation, 0);
    check("t6_async_tick", frame_tick, 0);
    cyc();
    reset = 1'b0;
    cyc();
    check("t6_post_frame", frame, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
